raiz_arbiter: RTL and testbench
===============================

// Module: raiz_arbiter
// PURPOSE
//  Shares one raiz_16 square-root core between N_REQ requesters. Round-robin arbitration, operand
//  capture, core sequencing (core_rst/core_init), result return tagged to the owner, timeout abort.
//  Sits between client blocks and the single raiz_16 instance; the only driver of that core.
// PARAMETERS
//  N_REQ    4   number of requesters (2..8)
//  WIDTH    16  operand/result width; must equal the core width
//  TIMEOUT  64  max RUN cycles waiting for core_DONE before abort (>=4)
// PORTS
//  clk        in   1              system clock, rising edge
//  rst        in   1              synchronous, active-high reset
//  in_req     in   N_REQ          request level per requester; held until out_ack
//  in_RR      in   N_REQ*WIDTH    operands; requester i at [i*WIDTH +: WIDTH]
//  out_ack    out  N_REQ          one-hot 1-cycle pulse: operand of requester i captured
//  out_valid  out  N_REQ          one-hot 1-cycle pulse: out_Q/out_R/out_err belong to requester i
//  out_Q      out  WIDTH          root, held until next out_valid
//  out_R      out  WIDTH          remainder, held until next out_valid
//  out_err    out  1              high with out_valid when the op timed out
//  out_busy   out  1              high in every state except IDLE
//  core_rst   out  1              to core rst
//  core_init  out  1              to core init
//  core_RR    out  WIDTH          to core in_RR, registered operand
//  core_Q     in   WIDTH          from core out_Q
//  core_R     in   WIDTH          from core out_R
//  core_DONE  in   1              from core out_DONE
// BEHAVIOUR
//  Reset: state=IDLE, ptr=0, all outputs 0 except core_rst=1 while rst high. All outputs registered.
//  States: IDLE -> START -> RUN -> DELIVER -> IDLE; RUN -> ABORT -> DELIVER on timeout.
//  IDLE: scan in_req from ptr upward, wrap at N_REQ; first set bit i wins. Next edge: state=START,
//   owner=i, core_RR=in_RR[i], out_ack[i]=1, ptr=(i+1) mod N_REQ. No request: stay IDLE.
//  START (1 cycle): core_init=1; out_ack back to 0; cnt=0; next RUN.
//  RUN: core_init=0; cnt+1 each cycle. core_DONE ignored in first RUN cycle (stale level guard);
//   from 2nd cycle, core_DONE=1 -> latch core_Q/core_R into out_Q/out_R, out_err=0, go DELIVER.
//   cnt reaching TIMEOUT without DONE -> ABORT.
//  ABORT (1 cycle): core_rst=1; out_Q=0, out_R=0, out_err=1; next DELIVER.
//  DELIVER (1 cycle): out_valid[owner]=1; next IDLE. New grant earliest the cycle after.
//  Latency: out_ack to out_valid = core DONE cycle + 1; DONE in RUN cycle t -> out_valid at t+1.
//  Requests only sampled in IDLE; requests raised while busy wait. Requester may drop in_req
//   any time before ack (withdrawn, no ack) and must drop or re-raise after ack as new request.
//  Same requester re-raised immediately is served after all others pending (ptr moved past it).
//  core_DONE outside RUN ignored. One op in flight max; no queueing of operands.
//  rst mid-op: immediate return to IDLE, no out_valid emitted, ptr=0, core_rst=1 during rst.
//  out_busy = (state != IDLE).
// TESTING
//  1 single req: in_req=4'b0100, RR[2]=144 -> ack[2] once, core_init 1 cycle, valid[2], Q=12, R=0, err=0.
//  2 max operand: req0, RR=65535 -> Q=255, R=510; req1 RR=0 -> Q=0, R=0; valid one-hot each.
//  3 all four req held from reset -> acks in order 0,1,2,3, then 0 again; never two acks/valids same cycle.
//  4 fairness: req0 held constantly + req1 pulsed after each ack -> grants alternate 0,1,0,1.
//  5 timeout: core model never DONE, TIMEOUT=16 -> core_rst 1 cycle after 16 RUN cycles, valid+err=1, Q=R=0.
//  6 rst high in RUN cycle 3 -> next cycle IDLE, out_busy=0, no out_valid; next req granted from ptr=0.

Source files
------------

// File: rtl/raiz_arbiter.sv
// Round-robin front end for a single shared raiz_16 square-root core.
// Grants one requester at a time, sequences the core, and returns the result to the owner.
module raiz_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       in_req,
  input  logic [N_REQ*WIDTH-1:0] in_RR,
  output logic [N_REQ-1:0]       out_ack,
  output logic [N_REQ-1:0]       out_valid,
  output logic [WIDTH-1:0]       out_Q,
  output logic [WIDTH-1:0]       out_R,
  output logic                   out_err,
  output logic                   out_busy,
  output logic                   core_rst,
  output logic                   core_init,
  output logic [WIDTH-1:0]       core_RR,
  input  logic [WIDTH-1:0]       core_Q,
  input  logic [WIDTH-1:0]       core_R,
  input  logic                   core_DONE
);

  localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    RUN,
    ABORT,
    DELIVER
  } state_t;

  state_t           state;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    owner;
  logic [CW-1:0]    cnt;
  logic             grant_found;
  logic [PW-1:0]    grant_idx;
  logic [PW-1:0]    scan_idx;
  logic [WIDTH-1:0] operand [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_operand
    assign operand[g] = in_RR[g*WIDTH +: WIDTH];
  end

  // Scan starts at ptr and wraps, so the first hit is the round-robin winner.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      scan_idx = PW'((32'(ptr) + k) % N_REQ);
      if (!grant_found && in_req[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      owner     <= '0;
      cnt       <= '0;
      out_ack   <= '0;
      out_valid <= '0;
      out_Q     <= '0;
      out_R     <= '0;
      out_err   <= 1'b0;
      out_busy  <= 1'b0;
      core_rst  <= 1'b1;
      core_init <= 1'b0;
      core_RR   <= '0;
    end else begin
      out_ack   <= '0;
      out_valid <= '0;
      core_init <= 1'b0;
      core_rst  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_found) begin
            state              <= START;
            owner              <= grant_idx;
            core_RR            <= operand[grant_idx];
            out_ack[grant_idx] <= 1'b1;
            core_init          <= 1'b1;
            out_busy           <= 1'b1;
            ptr                <= (32'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + 1'b1;
          end
        end
        START: begin
          state <= RUN;
          cnt   <= '0;
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          // cnt==0 is the first RUN cycle: DONE may still be left over from the previous op.
          if (core_DONE && (cnt != '0)) begin
            out_Q            <= core_Q;
            out_R            <= core_R;
            out_err          <= 1'b0;
            out_valid[owner] <= 1'b1;
            state            <= DELIVER;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            core_rst <= 1'b1;
            state    <= ABORT;
          end
        end
        ABORT: begin
          out_Q            <= '0;
          out_R            <= '0;
          out_err          <= 1'b1;
          out_valid[owner] <= 1'b1;
          state            <= DELIVER;
        end
        DELIVER: begin
          out_busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          out_busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_raiz_arbiter.sv
// Bench for raiz_arbiter: behavioural core model plus a transaction-level reference
// that predicts grant order, result timing and values from the arbitration rules.
module tb_raiz_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 16;
  localparam int unsigned TO = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   in_req = '0;
  logic [N*W-1:0] in_RR = '0;
  logic [N-1:0]   out_ack, out_valid;
  logic [W-1:0]   out_Q, out_R, core_RR, core_Q, core_R;
  logic           out_err, out_busy, core_rst, core_init, core_DONE;

  raiz_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .in_req(in_req), .in_RR(in_RR),
    .out_ack(out_ack), .out_valid(out_valid), .out_Q(out_Q), .out_R(out_R),
    .out_err(out_err), .out_busy(out_busy), .core_rst(core_rst), .core_init(core_init),
    .core_RR(core_RR), .core_Q(core_Q), .core_R(core_R), .core_DONE(core_DONE)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, n);
    end
  endtask

  function automatic int unsigned isqrt(input int unsigned v);
    int unsigned r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  // Behavioural core: DONE is a level that stays up until the core is reset or one
  // edge after a new init, so a stale DONE is visible in the first RUN cycle.
  int           core_lat_cfg = 1;
  int           cd = -1;
  logic         c_done = 1'b0;
  logic [W-1:0] c_q = '0, c_r = '0;
  assign core_DONE = c_done;
  assign core_Q    = c_q;
  assign core_R    = c_r;

  always @(posedge clk) begin
    if (core_rst) begin
      c_done <= 1'b0;
      cd     <= -1;
    end else if (core_init) begin
      cd  <= core_lat_cfg;
      c_q <= W'(isqrt(32'(core_RR)));
      c_r <= W'(32'(core_RR) - isqrt(32'(core_RR)) * isqrt(32'(core_RR)));
    end else if (cd > 0) begin
      cd     <= cd - 1;
      c_done <= (cd == 1);
    end
  end

  // Reference state: at most one transaction in flight, described by its cycle numbers.
  int           n = 0;
  int           idle_from = 0;
  int           last_rst = -10;
  int           rst_at = -1;
  int           ptr_m = 0;
  logic         in_flight = 1'b0;
  int           f_owner, f_ack, f_valid, f_abort;
  logic [W-1:0] f_op;
  logic         f_err;
  int           n_done = 0;
  int           force_lat = -1;
  logic         rand_mode = 1'b0;
  logic [N-1:0] req_set = '0;
  logic [N-1:0] rearm = '0;
  logic [W-1:0] set_rr [N];
  logic [N-1:0] ack_log [$];
  logic [W-1:0] last_q, last_r;
  logic         last_err;
  int           last_owner;

  task automatic step();
    logic [N-1:0] e_ack;
    logic [N-1:0] e_valid;
    int           lat;
    int           w;
    e_ack   = '0;
    e_valid = '0;
    @(negedge clk);
    if (n > 0) begin
      if (in_flight && n == f_ack)   e_ack[f_owner]   = 1'b1;
      if (in_flight && n == f_valid) e_valid[f_owner] = 1'b1;
      check("ack", out_ack, e_ack);
      check("valid", out_valid, e_valid);
      check("busy", out_busy, in_flight && n >= f_ack && n <= f_valid);
      check("core_rst", core_rst, (last_rst == n - 1) || (in_flight && n == f_abort));
      check("core_init", core_init, in_flight && n == f_ack);
      if (out_ack != '0) ack_log.push_back(out_ack);
      if (in_flight && n == f_ack) check("core_rr", core_RR, f_op);
      if (in_flight && n == f_valid) begin
        check("out_q", out_Q, f_err ? 0 : isqrt(f_op));
        check("out_r", out_R, f_err ? 0 : f_op - isqrt(f_op) * isqrt(f_op));
        check("out_err", out_err, f_err);
        last_q     = out_Q;
        last_r     = out_R;
        last_err   = out_err;
        last_owner = f_owner;
        in_flight  = 1'b0;
        idle_from  = n + 1;
        n_done++;
      end
    end

    for (int i = 0; i < N; i++) begin
      if (e_ack[i]) begin
        if (rearm[i] || (rand_mode && $urandom_range(0, 1) == 0)) begin
          in_req[i] = 1'b1;
          in_RR[i*W +: W] = W'($urandom);
        end else begin
          in_req[i] = 1'b0;
        end
      end else if (rand_mode) begin
        if (!in_req[i] && $urandom_range(0, 3) == 0) begin
          in_req[i] = 1'b1;
          in_RR[i*W +: W] = W'($urandom);
        end else if (in_req[i] && $urandom_range(0, 31) == 0) begin
          in_req[i] = 1'b0;
        end
      end
      if (req_set[i]) begin
        in_req[i] = 1'b1;
        in_RR[i*W +: W] = set_rr[i];
      end
    end
    req_set = '0;
    rst = (n < 3) || (n == rst_at);

    if (rst) begin
      in_flight = 1'b0;
      ptr_m     = 0;
      idle_from = n + 1;
      last_rst  = n;
    end else if (!in_flight && n >= idle_from && in_req != '0) begin
      w = -1;
      for (int k = 0; k < N; k++)
        if (w < 0 && in_req[(ptr_m + k) % N]) w = (ptr_m + k) % N;
      if (force_lat >= 0) lat = force_lat;
      else if ($urandom_range(0, 7) == 0) lat = $urandom_range(TO - 1, TO + 2);
      else lat = $urandom_range(1, 6);
      core_lat_cfg = lat;
      in_flight = 1'b1;
      f_owner   = w;
      f_op      = in_RR[w*W +: W];
      f_ack     = n + 1;
      if (lat + 1 <= TO) begin
        f_valid = n + 3 + lat;
        f_abort = -1;
        f_err   = 1'b0;
      end else begin
        f_abort = n + TO + 2;
        f_valid = n + TO + 3;
        f_err   = 1'b1;
      end
      ptr_m = (w + 1) % N;
    end
    n++;
  endtask

  task automatic wait_ops(input int k, input int budget);
    int target;
    int i;
    target = n_done + k;
    i = 0;
    while (n_done < target && i < budget) begin
      step();
      i++;
    end
    check("wait_bound", n_done >= target, 1);
  endtask

  initial begin
    int s;
    int a;
    int guard;
    repeat (5) step();

    force_lat = 3;
    set_rr[2] = 16'd144;
    req_set   = 4'b0100;
    wait_ops(1, 40);
    check("t1_q", last_q, 12);
    check("t1_r", last_r, 0);
    check("t1_err", last_err, 0);
    check("t1_owner", last_owner, 2);

    set_rr[0] = 16'hFFFF;
    req_set   = 4'b0001;
    wait_ops(1, 40);
    check("t2_q_max", last_q, 255);
    check("t2_r_max", last_r, 510);
    set_rr[1] = 16'd0;
    req_set   = 4'b0010;
    wait_ops(1, 40);
    check("t2_q_zero", last_q, 0);
    check("t2_r_zero", last_r, 0);

    // round robin from a fresh reset with every requester held
    force_lat = -1;
    rst_at = n;
    step();
    for (int i = 0; i < N; i++) set_rr[i] = W'($urandom);
    s = ack_log.size();
    req_set = 4'b1111;
    rearm   = 4'b1111;
    wait_ops(5, 200);
    rearm = '0;
    wait_ops(4, 200);
    for (int k = 0; k < 9; k++)
      if (s + k < ack_log.size()) check("t3_order", ack_log[s + k], 32'(1) << (k % 4));
      else check("t3_count", ack_log.size(), s + 9);

    rst_at = n;
    step();
    s = ack_log.size();
    req_set = 4'b0011;
    rearm   = 4'b0011;
    wait_ops(6, 200);
    rearm = '0;
    wait_ops(2, 100);
    for (int k = 0; k < 6; k++)
      if (s + k < ack_log.size()) check("t4_alt", ack_log[s + k], 32'(1) << (k % 2));
      else check("t4_count", ack_log.size(), s + 6);

    force_lat = 1000;
    set_rr[3] = 16'd200;
    req_set   = 4'b1000;
    wait_ops(1, 60);
    check("t5_err", last_err, 1);
    check("t5_q", last_q, 0);
    check("t5_r", last_r, 0);
    force_lat = TO - 1;
    set_rr[3] = 16'd81;
    req_set   = 4'b1000;
    wait_ops(1, 60);
    check("t5_edge_ok", last_err, 0);
    check("t5_edge_q", last_q, 9);
    force_lat = TO;
    req_set   = 4'b1000;
    wait_ops(1, 60);
    check("t5_edge_to", last_err, 1);

    // reset during the third RUN cycle; waiting requests then restart from ptr 0
    force_lat = 10;
    set_rr[2] = 16'd99;
    req_set   = 4'b0100;
    guard = 0;
    while (!in_flight && guard < 20) begin
      step();
      guard++;
    end
    check("t6_granted", in_flight, 1);
    a = f_ack;
    guard = 0;
    while (n < a + 3 && guard < 20) begin
      step();
      guard++;
    end
    rst_at = n;
    set_rr[1] = 16'd49;
    set_rr[3] = 16'd64;
    req_set   = 4'b1010;
    s = ack_log.size();
    repeat (3) step();
    check("t6_next_grant", (ack_log.size() > s) ? ack_log[s] : '0, 4'b0010);
    force_lat = -1;
    wait_ops(2, 100);

    rand_mode = 1'b1;
    repeat (2500) step();
    rand_mode = 1'b0;
    rearm = '0;
    guard = 0;
    while ((in_req != '0 || in_flight) && guard < 1000) begin
      step();
      guard++;
    end
    check("drain", (in_req == '0) && !in_flight, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
